// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage feeding a one-bit-per-clock
// pattern detector. WIDTH-bit words arrive over a valid/ready handshake and
// leave one bit per clk. A shift register plus one holding register lets
// consecutive words stream without gap bits. When nothing is shifting,
// ser_out carries IDLE_BIT.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous, active-high reset
//   in_data    - parallel word to serialize
//   in_valid   - in_data valid this cycle
//   in_ready   - a word can be accepted this cycle (registered state only)
//   ser_out    - serial bit stream
//   ser_active - ser_out carries a data bit rather than idle fill
//   word_start - first bit of a word is on ser_out
//   word_done  - last bit of a word is on ser_out
module piso_serializer #(
   parameter int   WIDTH     = 8,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_active,
   output logic             word_start,
   output logic             word_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hold_full_q, hold_full_d;

   logic             accept;
   logic [WIDTH-1:0] sh_shifted;
   logic             out_bit;

   assign in_ready = !hold_full_q;
   assign accept   = in_valid && !hold_full_q;

   // Shift toward whichever end is presented on ser_out.
   always_comb begin
      if (MSB_FIRST != 0) begin
         sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
         out_bit    = sh_q[WIDTH-1];
      end else begin
         sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
         out_bit    = sh_q[0];
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sh_d    = in_data;
               cnt_d   = CNT_LAST;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               sh_d  = sh_shifted;
               cnt_d = cnt_q - CW'(1);
               if (accept) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // Last bit out: reload from hold so the next word follows gaplessly.
               sh_d        = hold_q;
               cnt_d       = CNT_LAST;
               hold_full_d = 1'b0;
            end else if (in_valid) begin
               // Hold is empty (in_ready=1): load the incoming word directly.
               sh_d  = in_data;
               cnt_d = CNT_LAST;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign ser_active = (state_q == SHIFT);
   assign ser_out    = (state_q == SHIFT) ? out_bit : IDLE_BIT;
   assign word_start = (state_q == SHIFT) && (cnt_q == CNT_LAST);
   assign word_done  = (state_q == SHIFT) && (cnt_q == '0);

endmodule
